// File: rtl/ahf_pb_sw_conditioner.sv
// ahf_pb_sw_conditioner
// Board-side input front end for the RISC521 CPU input port.
// - Synchronizes and debounces four slide switches and four pushbuttons.
// - Turns debounced pushbutton presses into event flags for software.
//
// Build option AHF_PB_STICKY_EN:
// - Defined: PB_event holds sticky set/clear flags, and PB_clr acknowledges them.
// - Undefined (default): PB_event is a one-cycle pulse per debounced press,
//   and PB_clr is ignored.
//
// Every bit (4 switches + 4 buttons) runs through an identical channel:
// - a two-flop synchronizer;
// - a debounced level register;
// - a stability counter that must see DEBOUNCE_CYCLES consecutive
//   disagreeing samples before the level register follows the input.

`default_nettype none

module ahf_pb_sw_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [3:0] SW_raw,
    input  logic [3:0] PB_raw,
    input  logic [3:0] PB_clr,
    output logic [3:0] SW_in,
    output logic [3:0] PB_in,
    output logic [3:0] PB_event
);

    // Channel layout: bits [3:0] are switches, bits [7:4] are pushbuttons.
    localparam int unsigned N_CH  = 8;
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 32'd2) ? 1 : $clog2(DEBOUNCE_CYCLES + 32'd1);

    // Terminal count: the sample that completes the stability window.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);

    // Raw pins gathered into one channel vector.
    logic [N_CH-1:0]  raw_s;

    // Per-channel state.
    logic [N_CH-1:0]  sync1_r;
    logic [N_CH-1:0]  sync2_r;
    logic [N_CH-1:0]  stable_r;
    logic [CNT_W-1:0] cnt_r [N_CH];

    // Next-state values for the debounce registers.
    logic [N_CH-1:0]  stable_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s [N_CH];

    // Press detection and event flag logic.
    logic [3:0]       press_s;
    logic [3:0]       event_nxt_s;
    logic [3:0]       event_r;

    assign raw_s = {PB_raw, SW_raw};

    // Debounce rule per channel, in priority order:
    // - agreement restarts the window;
    // - the last disagreeing sample of a full window moves the level;
    // - otherwise the counter advances.
    // The counter is cleared both on agreement and on terminal count, so it never wraps.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            stable_nxt_s[i] = stable_r[i];
            cnt_nxt_s[i]    = cnt_r[i];
            if (sync2_r[i] == stable_r[i]) begin
                cnt_nxt_s[i] = CNT_ZERO;
            end else if (cnt_r[i] == CNT_LAST) begin
                stable_nxt_s[i] = sync2_r[i];
                cnt_nxt_s[i]    = CNT_ZERO;
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
            end
        end
    end

    // Press: the edge at which a debounced button level moves from 0 to 1.
    // Releases fall out naturally because only the rising transition is kept.
    always_comb begin
        press_s = stable_nxt_s[7:4] & ~stable_r[7:4];
    end

`ifdef AHF_PB_STICKY_EN
    // Sticky flags: set on press, clear on acknowledge; a same-edge press wins.
    // A press while the flag is already set is absorbed.
    always_comb begin
        event_nxt_s = press_s | (event_r & ~PB_clr);
    end
`else
    // Acknowledge input has no function in pulse mode.
    logic unused_clr_s;
    assign unused_clr_s = ^PB_clr;

    // Pulse flags: one registered cycle per debounced press.
    always_comb begin
        event_nxt_s = press_s;
    end
`endif

    // Synchronizer, debounce and event registers.
    // The reset clears every flop, so a partial count is discarded, and a
    // button held through reset is seen as a fresh 0->1 once it debounces.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync1_r  <= '0;
            sync2_r  <= '0;
            stable_r <= '0;
            event_r  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
        end else begin
            sync1_r  <= raw_s;
            sync2_r  <= sync1_r;
            stable_r <= stable_nxt_s;
            event_r  <= event_nxt_s;
            for (int i = 0; i < N_CH; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

    // Outputs come straight from flops; no input reaches an output combinationally.
    assign SW_in    = stable_r[3:0];
    assign PB_in    = stable_r[7:4];
    assign PB_event = event_r;

endmodule

`default_nettype wire

// File: tb/tb_ahf_pb_sw_conditioner.sv
// Testbench for ahf_pb_sw_conditioner with DEBOUNCE_CYCLES = 4.
// Expected output states are pushed to a scoreboard with the clock edge at which
// they must hold. A negedge monitor pops and compares the entries that fall due.
// Event persistence expectations follow AHF_PB_STICKY_EN.

`timescale 1ns/1ps

module tb_ahf_pb_sw_conditioner;

    localparam int unsigned DEB = 4;

`ifdef AHF_PB_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic       Clock;
    logic       Reset;
    logic [3:0] SW_raw;
    logic [3:0] PB_raw;
    logic [3:0] PB_clr;
    logic [3:0] SW_in;
    logic [3:0] PB_in;
    logic [3:0] PB_event;

    ahf_pb_sw_conditioner #(.DEBOUNCE_CYCLES(DEB)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .SW_raw   (SW_raw),
        .PB_raw   (PB_raw),
        .PB_clr   (PB_clr),
        .SW_in    (SW_in),
        .PB_in    (PB_in),
        .PB_event (PB_event)
    );

    typedef struct {
        int         cyc;
        logic [3:0] sw;
        logic [3:0] pb;
        logic [3:0] ev;
        string      tag;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Count rising edges; after edge n the value is n.
    always @(posedge Clock) cyc = cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_exp(input int c, input logic [3:0] sw, input logic [3:0] pb,
                            input logic [3:0] ev, input string tag);
        exp_t e;
        e.cyc = c;
        e.sw  = sw;
        e.pb  = pb;
        e.ev  = ev;
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge Clock);
    endtask

    // Drive steady raw levels, let them debounce, and acknowledge any pending events.
    task automatic settle(input logic [3:0] sw, input logic [3:0] pb);
        SW_raw = sw;
        PB_raw = pb;
        step(10);
        PB_clr = 4'b1111;
        push_exp(cyc + 1, sw, pb, 4'b0000, "settle");
        step(1);
        PB_clr = 4'b0000;
        step(2);
    endtask

    // Scoreboard monitor: compare every entry that is due at this cycle.
    always @(negedge Clock) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].cyc < cyc) begin
                check_eq({sb_q[i].tag, "_missed"}, 32'(cyc), 32'(sb_q[i].cyc));
                sb_q.delete(i);
            end else if (sb_q[i].cyc == cyc) begin
                check_eq({sb_q[i].tag, "_sw"}, 32'(SW_in),    32'(sb_q[i].sw));
                check_eq({sb_q[i].tag, "_pb"}, 32'(PB_in),    32'(sb_q[i].pb));
                check_eq({sb_q[i].tag, "_ev"}, 32'(PB_event), 32'(sb_q[i].ev));
                sb_q.delete(i);
            end
        end
    end

    initial begin : stim
        int         k;
        int         m;
        int         j;
        int         c;
        int         r;
        int         p;
        logic [3:0] ev0;
        logic [3:0] ev9;

        ev0 = STICKY ? 4'b0001 : 4'b0000;
        ev9 = STICKY ? 4'b1001 : 4'b0000;

        Reset  = 1'b1;
        SW_raw = 4'b0101;
        PB_raw = 4'b0001;
        PB_clr = 4'b0000;

        // Reset values with raw inputs active.
        step(1);
        push_exp(cyc + 1, 4'b0000, 4'b0000, 4'b0000, "rst_hold1");
        push_exp(cyc + 2, 4'b0000, 4'b0000, 4'b0000, "rst_hold2");
        step(3);

        // Release, then pulse reset mid-count; the window must restart.
        k = cyc;
        Reset = 1'b0;
        push_exp(k + 4, 4'b0000, 4'b0000, 4'b0000, "mid_count");
        step(4);
        Reset = 1'b1;
        push_exp(cyc + 1, 4'b0000, 4'b0000, 4'b0000, "rst_pulse");
        step(1);
        Reset = 1'b0;
        m = cyc;
        push_exp(m + 5, 4'b0000, 4'b0000, 4'b0000, "rst_restart_pre");
        push_exp(m + 6, 4'b0101, 4'b0001, 4'b0001, "rst_restart");
        push_exp(m + 7, 4'b0101, 4'b0001, ev0,     "rst_restart_after");
        step(10);
        settle(4'b0000, 4'b0000);

        // Switch latency: exactly DEB+2 edges.
        k = cyc;
        SW_raw = 4'b0101;
        push_exp(k + 5,  4'b0000, 4'b0000, 4'b0000, "sw_pre");
        push_exp(k + 6,  4'b0101, 4'b0000, 4'b0000, "sw_update");
        push_exp(k + 30, 4'b0101, 4'b0000, 4'b0000, "sw_hold");
        step(31);

        // Bounce rejection: 3 high, 2 low, 3 high, then low.
        k = cyc;
        PB_raw = 4'b0001;
        push_exp(k + 6,  4'b0101, 4'b0000, 4'b0000, "bounce_a");
        push_exp(k + 9,  4'b0101, 4'b0000, 4'b0000, "bounce_b");
        push_exp(k + 12, 4'b0101, 4'b0000, 4'b0000, "bounce_c");
        push_exp(k + 20, 4'b0101, 4'b0000, 4'b0000, "bounce_d");
        step(3);
        PB_raw = 4'b0000;
        step(2);
        PB_raw = 4'b0001;
        step(3);
        PB_raw = 4'b0000;
        step(15);

        // A 5-cycle high is long enough; its release produces no event.
        j = cyc;
        PB_raw = 4'b0001;
        push_exp(j + 5,  4'b0101, 4'b0000, 4'b0000, "pulse5_pre");
        push_exp(j + 6,  4'b0101, 4'b0001, 4'b0001, "pulse5_press");
        push_exp(j + 7,  4'b0101, 4'b0001, ev0,     "pulse5_after");
        push_exp(j + 10, 4'b0101, 4'b0001, ev0,     "pulse5_held");
        push_exp(j + 11, 4'b0101, 4'b0000, ev0,     "pulse5_release");
        step(5);
        PB_raw = 4'b0000;
        step(10);
        settle(4'b0101, 4'b0000);

        // Press held for 30 cycles, then acknowledge.
        k = cyc;
        PB_raw = 4'b0001;
        push_exp(k + 5,  4'b0101, 4'b0000, 4'b0000, "press_pre");
        push_exp(k + 6,  4'b0101, 4'b0001, 4'b0001, "press_set");
        push_exp(k + 36, 4'b0101, 4'b0001, ev0,     "press_hold30");
        step(36);
        c = cyc;
        PB_clr = 4'b0001;
        push_exp(c + 1, 4'b0101, 4'b0001, 4'b0000, "clr");
        step(1);
        PB_clr = 4'b0000;

        // Release: no event.
        r = cyc;
        PB_raw = 4'b0000;
        push_exp(r + 5, 4'b0101, 4'b0001, 4'b0000, "release_pre");
        push_exp(r + 6, 4'b0101, 4'b0000, 4'b0000, "release");
        push_exp(r + 7, 4'b0101, 4'b0000, 4'b0000, "release_after");
        step(10);

        // Re-press with a clear on the same edge as the press.
        p = cyc;
        PB_raw = 4'b0001;
        push_exp(p + 5, 4'b0101, 4'b0000, 4'b0000, "repress_pre");
        push_exp(p + 6, 4'b0101, 4'b0001, 4'b0001, "repress_set_vs_clr");
        push_exp(p + 7, 4'b0101, 4'b0001, ev0,     "repress_after");
        step(5);
        PB_clr = 4'b0001;
        step(1);
        PB_clr = 4'b0000;
        step(3);
        settle(4'b0101, 4'b0000);

        // Simultaneous press on buttons 0 and 3 while clearing unrelated bits.
        k = cyc;
        PB_raw = 4'b1001;
        push_exp(k + 5, 4'b0101, 4'b0000, 4'b0000, "multi_pre");
        push_exp(k + 6, 4'b0101, 4'b1001, 4'b1001, "multi_press");
        push_exp(k + 7, 4'b0101, 4'b1001, ev9,     "multi_after");
        push_exp(k + 9, 4'b0101, 4'b1001, ev9,     "multi_later");
        step(2);
        PB_clr = 4'b0110;
        step(6);
        PB_clr = 4'b0000;
        step(4);

        // Drain the scoreboard within a bounded number of cycles.
        for (int n = 0; n < 50 && sb_q.size() > 0; n++) begin
            @(negedge Clock);
        end
        check_eq("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
